popcount_window_filter: RTL and testbench
=========================================

// Module: popcount_window_filter
// PURPOSE
//  Parametrised successor of the 4-input "2 or 3 ones" detector.
//  - Counts the ones in a WIDTH-bit input word.
//  - Flags a match when the count lies in a runtime-programmable window [lo,hi].
//  - Outputs are registered, so they are glitch-free by construction.
//  - hit_o is debounced: it asserts only after STABLE consecutive matching samples
//    and releases only after STABLE consecutive non-matching samples.
//  - Sits between raw sensor/flag buses and control logic that must not see glitches.
// PARAMETERS
//  WIDTH   4                   input word width, >=1
//  CNT_W   $clog2(WIDTH+1)     width of popcount and bounds (derived, do not override)
//  STABLE  2                   consecutive valid samples needed to set or clear hit_o, >=1
//  EVT_W   16                  width of the saturating hit-event counter
// PORTS
//  clk          in   1       clock, rising edge
//  nrst         in   1       synchronous reset, active low
//  in_valid     in   1       in_data is a sample this cycle
//  in_data      in   WIDTH   sample word
//  cfg_load     in   1       capture lo_i/hi_i into bound registers
//  lo_i         in   CNT_W   window lower bound (inclusive)
//  hi_i         in   CNT_W   window upper bound (inclusive)
//  count_o      out  CNT_W   registered popcount of last valid sample
//  match_o      out  1       registered lo<=count<=hi for last valid sample (unfiltered)
//  hit_o        out  1       debounced window indication
//  rise_o       out  1       1-cycle pulse on the first cycle hit_o is high
//  evt_count_o  out  EVT_W   number of rise_o pulses, saturating at all-ones
// BEHAVIOUR
//  Reset (nrst=0 at edge):
//  - All outputs and both pipeline valids go to 0.
//  - Bounds reset to lo=2, hi=3, matching the legacy function at WIDTH=4.
//  - FSM goes to IDLE.
//  Pipeline:
//  - S1: registers in_valid and in_data.
//  - S2: popcount and window compare on S1. When S1 is valid, updates count_o/match_o
//    and sets v2; otherwise count_o/match_o hold and v2=0.
//  - FSM consumes v2/match_o.
//  - Latency: sample at edge t -> count_o/match_o at t+2 -> hit_o/rise_o at t+3.
//  - Full throughput, one sample per cycle. No backpressure.
//  Window rules:
//  - Unsigned compare.
//  - lo>hi gives an empty window: match_o is always 0.
//  - lo=0,hi=WIDTH gives match_o=1 for every valid sample.
//  FSM (qcnt is a $clog2(STABLE+1)-bit run counter):
//  - Cycles with v2=0 never change state or qcnt.
//  - IDLE: match -> QUAL with qcnt=1 (straight to ACTIVE if STABLE=1).
//  - QUAL: match -> qcnt++, and ACTIVE when qcnt reaches STABLE; ~match -> IDLE.
//  - ACTIVE: ~match -> DROP with qcnt=1 (straight to IDLE if STABLE=1); match -> stay.
//  - DROP: ~match -> qcnt++, and IDLE when qcnt reaches STABLE; match -> ACTIVE.
//  - hit_o = (state is ACTIVE or DROP), registered.
//  - rise_o = 1 only on the cycle after an IDLE/QUAL -> ACTIVE transition.
//  - evt_count_o increments with rise_o. At all-ones it holds, no wrap.
//  cfg_load:
//  - Bounds update at the edge; samples still in S1/S2 are compared against the new bounds.
//  - The same edge forces the FSM to IDLE with qcnt=0 and clears hit_o.
//  - No rise_o is generated, and this has priority over that cycle's FSM update.
//  - evt_count_o is kept.
//  Reset mid-run: same result as power-on reset; any in-flight samples are discarded.
// STRUCTURE
//  - Package popcount_window_pkg: typedef enum logic [1:0] {IDLE,QUAL,ACTIVE,DROP} pwf_state_t;
//    localparams RST_LO=2, RST_HI=3.
//  - Sub-module popcount_tree #(WIDTH): purely combinational adder tree, in_data -> CNT_W count.
//  - Comparator, FSM and counters stay in the top.
// TESTING
//  - WIDTH=4, reset bounds, all 16 values, one valid sample each: match_o=1 exactly for
//    popcount 2 or 3 (legacy table), seen 2 cycles after each sample.
//  - STABLE=2: valid samples 4'b0011,4'b0110 -> hit_o=1 and rise_o=1 three cycles after
//    the 2nd sample; then 4'b0001 alone -> hit_o stays 1; 4'b0001,4'b0000 -> hit_o=0.
//  - Match, in_valid=0 for 5 cycles, match -> hit asserts (invalid gaps do not break
//    the run); evt_count_o=1.
//  - cfg_load lo=3,hi=1 while ACTIVE -> hit_o=0 next cycle with no rise_o; all later
//    samples give match_o=0.
//  - EVT_W=2: 5 separate hit episodes -> evt_count_o = 1,2,3,3,3.
//  - nrst=0 while in QUAL with samples in flight -> all outputs 0, bounds 2/3;
//    no stale match_o after release.

Source files
------------

// File: rtl/popcount_window_pkg.sv
// Shared types and reset constants for the popcount window filter.
package popcount_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUAL   = 2'd1,
    ACTIVE = 2'd2,
    DROP   = 2'd3
  } pwf_state_t;

  // Reset window reproduces the legacy "2 or 3 ones" detector at WIDTH=4.
  localparam int RST_LO = 2;
  localparam int RST_HI = 3;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a WIDTH-bit word.
module popcount_tree #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Sum of the input bits; synthesis balances the adder chain into a tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_window_filter.sv
// Popcount window detector with registered outputs and a debounced hit indication.
module popcount_window_filter
  import popcount_window_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = $clog2(WIDTH + 1),
  parameter int STABLE = 2,
  parameter int EVT_W  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] lo_i,
  input  logic [CNT_W-1:0] hi_i,
  output logic [CNT_W-1:0] count_o,
  output logic             match_o,
  output logic             hit_o,
  output logic             rise_o,
  output logic [EVT_W-1:0] evt_count_o
);

  localparam int QW = $clog2(STABLE + 1);
  localparam logic [QW-1:0] STABLE_Q = QW'(STABLE);
  localparam logic [QW-1:0] ONE_Q    = QW'(1);

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             v2_q, v2_d;
  pwf_state_t       state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             hit_q, hit_d;
  logic             rise_q, rise_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] pop_s;

  popcount_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_tree (
    .data_i  (d1_q),
    .count_o (pop_s)
  );

  // Input stage, bound registers and compare stage.
  always_comb begin
    v1_d    = in_valid;
    d1_d    = in_data;
    lo_d    = lo_q;
    hi_d    = hi_q;
    count_d = count_q;
    match_d = match_q;
    v2_d    = v1_q;
    if (cfg_load) begin
      lo_d = lo_i;
      hi_d = hi_i;
    end else begin
      lo_d = lo_q;
      hi_d = hi_q;
    end
    // Compare against the bounds taking effect at this edge, so a freshly loaded
    // window already applies to the sample leaving S1.
    if (v1_q) begin
      count_d = pop_s;
      match_d = (pop_s >= lo_d) && (pop_s <= hi_d);
    end else begin
      count_d = count_q;
      match_d = match_q;
    end
  end

  // Debounce FSM, rise pulse and saturating event counter.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    rise_d  = 1'b0;
    if (cfg_load) begin
      state_d = IDLE;
      qcnt_d  = '0;
    end else if (v2_q) begin
      case (state_q)
        IDLE: begin
          if (match_q) begin
            qcnt_d  = ONE_Q;
            state_d = (STABLE == 1) ? ACTIVE : QUAL;
            rise_d  = (STABLE == 1);
          end else begin
            state_d = IDLE;
          end
        end
        QUAL: begin
          if (match_q) begin
            qcnt_d = qcnt_q + ONE_Q;
            if ((qcnt_q + ONE_Q) == STABLE_Q) begin
              state_d = ACTIVE;
              rise_d  = 1'b1;
            end else begin
              state_d = QUAL;
            end
          end else begin
            state_d = IDLE;
            qcnt_d  = '0;
          end
        end
        ACTIVE: begin
          if (!match_q) begin
            qcnt_d  = ONE_Q;
            state_d = (STABLE == 1) ? IDLE : DROP;
          end else begin
            state_d = ACTIVE;
          end
        end
        DROP: begin
          if (!match_q) begin
            qcnt_d = qcnt_q + ONE_Q;
            if ((qcnt_q + ONE_Q) == STABLE_Q) begin
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end else begin
            state_d = ACTIVE;
          end
        end
        default: begin
          state_d = IDLE;
          qcnt_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    hit_d = (state_d == ACTIVE) || (state_d == DROP);
    if (rise_d && (evt_q != {EVT_W{1'b1}})) begin
      evt_d = evt_q + EVT_W'(1);
    end else begin
      evt_d = evt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      lo_q    <= CNT_W'(RST_LO);
      hi_q    <= CNT_W'(RST_HI);
      count_q <= '0;
      match_q <= 1'b0;
      v2_q    <= 1'b0;
      state_q <= IDLE;
      qcnt_q  <= '0;
      hit_q   <= 1'b0;
      rise_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      match_q <= match_d;
      v2_q    <= v2_d;
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      hit_q   <= hit_d;
      rise_q  <= rise_d;
      evt_q   <= evt_d;
    end
  end

  assign count_o     = count_q;
  assign match_o     = match_q;
  assign hit_o       = hit_q;
  assign rise_o      = rise_q;
  assign evt_count_o = evt_q;

endmodule

// File: tb/tb_popcount_window_filter.sv
// Directed self-checking bench for popcount_window_filter (WIDTH=4, STABLE=2).
module tb_popcount_window_filter;

  logic        clk = 1'b0;
  logic        nrst, in_valid, cfg_load;
  logic [3:0]  in_data;
  logic [2:0]  lo_i, hi_i;
  logic [2:0]  count_o, count_e;
  logic        match_o, hit_o, rise_o, match_e, hit_e, rise_e;
  logic [15:0] evt_count_o;
  logic [1:0]  evt_e;
  logic [15:0] legacy = 16'h7EE8;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  popcount_window_filter #(.WIDTH(4), .STABLE(2), .EVT_W(16)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .lo_i(lo_i), .hi_i(hi_i),
    .count_o(count_o), .match_o(match_o), .hit_o(hit_o), .rise_o(rise_o),
    .evt_count_o(evt_count_o)
  );

  popcount_window_filter #(.WIDTH(4), .STABLE(2), .EVT_W(2)) dut_e (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .lo_i(lo_i), .hi_i(hi_i),
    .count_o(count_e), .match_o(match_e), .hit_o(hit_e), .rise_o(rise_e),
    .evt_count_o(evt_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [3:0] d);
    in_valid = v;
    in_data  = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(1'b0, 4'd0);
  endtask

  task automatic do_reset();
    nrst = 1'b0; in_valid = 1'b0; in_data = 4'd0; cfg_load = 1'b0;
    step();
    step();
    nrst = 1'b1;
  endtask

  function automatic int pc4(input logic [3:0] d);
    int c = 0;
    for (int b = 0; b < 4; b++) c += int'(d[b]);
    return c;
  endfunction

  initial begin
    lo_i = 3'd0; hi_i = 3'd0;
    do_reset();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_match", 32'(match_o), 32'd0);
    check("rst_hit",   32'(hit_o),   32'd0);
    check("rst_rise",  32'(rise_o),  32'd0);
    check("rst_evt",   32'(evt_count_o), 32'd0);

    // Legacy table, one sample per cycle; result lags two edges.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) send(1'b1, 4'(i)); else send(1'b0, 4'd0);
      if (i >= 1 && i <= 16) begin
        check("tbl_count", 32'(count_o), 32'(pc4(4'(i - 1))));
        check("tbl_match", 32'(match_o), 32'(legacy[i - 1]));
      end
    end

    // Qualify, hold through a lone miss, then release after two misses.
    do_reset();
    send(1'b1, 4'b0011);
    send(1'b1, 4'b0110);
    idle(1);
    check("deb_hit_early", 32'(hit_o), 32'd0);
    idle(1);
    check("deb_hit_set",  32'(hit_o),  32'd1);
    check("deb_rise_set", 32'(rise_o), 32'd1);
    idle(1);
    check("deb_rise_pulse", 32'(rise_o), 32'd0);
    check("deb_hit_hold",   32'(hit_o),  32'd1);
    send(1'b1, 4'b0001);
    idle(3);
    check("deb_one_miss", 32'(hit_o), 32'd1);
    send(1'b1, 4'b0011);
    idle(2);
    check("deb_reenter_rise", 32'(rise_o), 32'd0);
    check("deb_reenter_hit",  32'(hit_o),  32'd1);
    idle(1);
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0000);
    idle(1);
    check("deb_drop_1", 32'(hit_o), 32'd1);
    idle(1);
    check("deb_drop_2", 32'(hit_o), 32'd0);
    check("deb_evt",    32'(evt_count_o), 32'd1);

    // Invalid gaps do not break the qualifying run.
    do_reset();
    send(1'b1, 4'b0011);
    idle(5);
    send(1'b1, 4'b1011);
    idle(1);
    check("gap_hit_early", 32'(hit_o), 32'd0);
    idle(1);
    check("gap_hit", 32'(hit_o), 32'd1);
    check("gap_evt", 32'(evt_count_o), 32'd1);

    // Empty window loaded while active.
    idle(2);
    cfg_load = 1'b1; lo_i = 3'd3; hi_i = 3'd1;
    send(1'b0, 4'd0);
    cfg_load = 1'b0;
    check("cfg_hit",  32'(hit_o),  32'd0);
    check("cfg_rise", 32'(rise_o), 32'd0);
    check("cfg_evt",  32'(evt_count_o), 32'd1);
    send(1'b1, 4'b0011); idle(1);
    check("cfg_m_0011", 32'(match_o), 32'd0);
    check("cfg_c_0011", 32'(count_o), 32'd2);
    send(1'b1, 4'b0111); idle(1);
    check("cfg_m_0111", 32'(match_o), 32'd0);
    send(1'b1, 4'b1111); idle(1);
    check("cfg_m_1111", 32'(match_o), 32'd0);
    check("cfg_c_1111", 32'(count_o), 32'd4);
    idle(2);
    check("cfg_hit_end", 32'(hit_o), 32'd0);

    // Reset in QUAL with samples in flight; bounds return to 2/3.
    do_reset();
    send(1'b1, 4'b0011);
    send(1'b1, 4'b0011);
    send(1'b1, 4'b0011);
    nrst = 1'b0;
    send(1'b0, 4'd0);
    check("mrst_count", 32'(count_o), 32'd0);
    check("mrst_match", 32'(match_o), 32'd0);
    check("mrst_hit",   32'(hit_o),   32'd0);
    check("mrst_rise",  32'(rise_o),  32'd0);
    nrst = 1'b1;
    idle(3);
    check("mrst_stale_match", 32'(match_o), 32'd0);
    check("mrst_stale_hit",   32'(hit_o),   32'd0);
    check("mrst_stale_count", 32'(count_o), 32'd0);
    send(1'b1, 4'b0011); idle(1);
    check("mrst_bnd_in", 32'(match_o), 32'd1);
    send(1'b1, 4'b1111); idle(1);
    check("mrst_bnd_hi", 32'(match_o), 32'd0);
    send(1'b1, 4'b0001); idle(1);
    check("mrst_bnd_lo", 32'(match_o), 32'd0);

    // Five hit episodes: 2-bit counter saturates, 16-bit one keeps counting.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, 4'b0011);
      send(1'b1, 4'b0101);
      send(1'b1, 4'b0000);
      send(1'b1, 4'b1000);
      idle(3);
      check("sat_evt2",  32'(evt_e), 32'((k < 3) ? k : 3));
      check("sat_evt16", 32'(evt_count_o), 32'(k));
    end
    check("sat_count_e", 32'(count_e), 32'd1);
    check("sat_match_e", 32'(match_e), 32'd0);
    check("sat_hit_e",   32'(hit_e),   32'd0);
    check("sat_rise_e",  32'(rise_e),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
